// File: rtl/jsilicon_pkg.sv
// Shared state encoding and framing constants for result_tx_scheduler.
// RESULT_TX_HEADER_EN adds the header states and a third byte per result.
package jsilicon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_HI  = 3'd1,
        ST_WAIT_HI  = 3'd2,
        ST_SEND_LO  = 3'd3,
        ST_WAIT_LO  = 3'd4
`ifdef RESULT_TX_HEADER_EN
        ,
        ST_SEND_HDR = 3'd5,
        ST_WAIT_HDR = 3'd6
`endif
    } tx_state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

`ifdef RESULT_TX_HEADER_EN
    localparam int BYTES_PER_RESULT = 3;
`else
    localparam int BYTES_PER_RESULT = 2;
`endif

endpackage

// File: rtl/result_tx_scheduler_fifo.sv
// Synchronous FIFO with registered occupancy count; head is read combinationally.
// Pushes on full and pops on empty are ignored.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_tx_scheduler.sv
// Queues 16-bit ALU results and sends each as hi/lo bytes over a shared UART.
// Define RESULT_TX_HEADER_EN to prefix every result with HDR_BYTE.
//
// state    | meaning
// IDLE     | nothing in flight; pops the FIFO head when ena and UART idle
// SEND_HDR | header start pulse (header build only)
// WAIT_HDR | guard cycle, then wait for UART idle (header build only)
// SEND_HI  | high-byte start pulse
// WAIT_HI  | guard cycle, then wait for UART idle
// SEND_LO  | low-byte start pulse
// WAIT_LO  | guard cycle, then wait; may pop the next result directly
module result_tx_scheduler
    import jsilicon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16
`ifdef RESULT_TX_HEADER_EN
    ,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
`endif
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ena,
    input  logic                        res_valid,
    input  logic [DATA_W-1:0]           res_data,
    output logic                        res_ready,
    input  logic                        uart_busy,
    output logic                        uart_start,
    output logic [7:0]                  uart_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e         state_q;
    logic              guard_q;
    logic              start_q;
    logic [7:0]        data_q;
    logic              ovf_q;
    logic              idle_q;
`ifdef RESULT_TX_HEADER_EN
    logic [DATA_W-1:0] hold_q;
`else
    logic [7:0]        hold_q;
`endif

    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              can_start;
    logic              to_idle;

    assign res_ready = ena && !full;
    assign push      = res_valid && res_ready;
    assign can_start = !empty && ena && !uart_busy;

    result_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(res_data),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // A new result is only ever started from IDLE or at the end of WAIT_LO.
    always_comb begin
        pop     = 1'b0;
        to_idle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop     = can_start;
                to_idle = !can_start;
            end
            ST_WAIT_LO: begin
                if (!guard_q && !uart_busy) begin
                    pop     = can_start;
                    to_idle = !can_start;
                end
            end
            default: ;
        endcase
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            guard_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            start_q <= 1'b0;
            idle_q  <= to_idle && (count_next == '0);
            if (res_valid && !res_ready && ena) begin
                ovf_q <= 1'b1;
            end
            if (pop) begin
                start_q <= 1'b1;
`ifdef RESULT_TX_HEADER_EN
                hold_q  <= head;
                data_q  <= HDR_BYTE;
                state_q <= ST_SEND_HDR;
`else
                hold_q  <= head[7:0];
                data_q  <= head[DATA_W-1 -: 8];
                state_q <= ST_SEND_HI;
`endif
            end else begin
                case (state_q)
`ifdef RESULT_TX_HEADER_EN
                    ST_SEND_HDR: begin
                        state_q <= ST_WAIT_HDR;
                        guard_q <= 1'b1;
                    end
                    ST_WAIT_HDR: begin
                        if (guard_q) begin
                            guard_q <= 1'b0;
                        end else if (!uart_busy) begin
                            state_q <= ST_SEND_HI;
                            start_q <= 1'b1;
                            data_q  <= hold_q[DATA_W-1 -: 8];
                        end
                    end
`endif
                    ST_SEND_HI: begin
                        state_q <= ST_WAIT_HI;
                        guard_q <= 1'b1;
                    end
                    ST_WAIT_HI: begin
                        if (guard_q) begin
                            guard_q <= 1'b0;
                        end else if (!uart_busy) begin
                            state_q <= ST_SEND_LO;
                            start_q <= 1'b1;
                            data_q  <= hold_q[7:0];
                        end
                    end
                    ST_SEND_LO: begin
                        state_q <= ST_WAIT_LO;
                        guard_q <= 1'b1;
                    end
                    ST_WAIT_LO: begin
                        if (guard_q) begin
                            guard_q <= 1'b0;
                        end else if (!uart_busy) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign uart_start = start_q;
    assign uart_data  = data_q;
    assign fifo_count = count;
    assign overflow   = ovf_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_result_tx_scheduler.sv
// Directed scenarios plus random traffic for result_tx_scheduler, checked against
// a byte-stream model: accepted results in order, framed per result, with occupancy.
`timescale 1ns/1ps
module tb_result_tx_scheduler;
    import jsilicon_pkg::*;

    localparam int DEPTH = 4;
    localparam int BPR   = BYTES_PER_RESULT;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        ena       = 1'b0;
    logic        res_valid = 1'b0;
    logic [15:0] res_data  = 16'h0000;
    logic        res_ready;
    logic        uart_busy;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int e0    = 0;

    int busy_cnt   = 0;
    int busy_len   = 10;
    bit rand_len   = 1'b0;
    bit force_busy = 1'b0;

    logic        pre_valid = 1'b0;
    logic        pre_ena   = 1'b0;
    logic        pre_busy  = 1'b0;
    logic [15:0] pre_data  = 16'h0000;

    logic [15:0] m_q[$];
    int          m_count  = 0;
    bit          m_ovf    = 1'b0;
    int          byte_idx = 0;
    logic [7:0]  exp_bytes [3];
    logic [7:0]  last_byte = 8'h00;
    bit          prev_start = 1'b0;
    logic [15:0] cur;
    int          start_log[$];

    always #5 clock = ~clock;

    assign uart_busy = force_busy || (busy_cnt != 0);

    result_tx_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .ena       (ena),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .uart_busy (uart_busy),
        .uart_start(uart_start),
        .uart_data (uart_data),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .idle      (idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // UART: goes busy on the edge it samples a start pulse, for a fixed or random length.
    always @(posedge clock) begin
        pre_valid <= res_valid;
        pre_ena   <= ena;
        pre_busy  <= uart_busy;
        pre_data  <= res_data;
        cyc       <= cyc + 1;
        if (reset)
            busy_cnt <= 0;
        else if (uart_start)
            busy_cnt <= rand_len ? int'($urandom_range(1, 6)) : busy_len;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    // Reference model, evaluated once per cycle for the edge that just passed.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_q.delete();
                m_count    = 0;
                m_ovf      = 1'b0;
                byte_idx   = 0;
                last_byte  = 8'h00;
                prev_start = 1'b0;
            end else begin
                if (pre_valid && pre_ena) begin
                    if (m_count < DEPTH) begin
                        m_q.push_back(pre_data);
                        m_count++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (uart_start) begin
                    check("start_pulse_width", prev_start, 0);
                    check("start_while_busy", pre_busy, 0);
                    if (byte_idx == 0) begin
                        check("pop_with_ena", pre_ena, 1);
                        check("pop_nonempty", m_q.size() > 0, 1);
                        if (m_q.size() > 0) begin
                            cur = m_q.pop_front();
                            m_count--;
`ifdef RESULT_TX_HEADER_EN
                            exp_bytes[0] = HDR_BYTE_DEFAULT;
                            exp_bytes[1] = cur[15:8];
                            exp_bytes[2] = cur[7:0];
`else
                            exp_bytes[0] = cur[15:8];
                            exp_bytes[1] = cur[7:0];
                            exp_bytes[2] = 8'h00;
`endif
                        end
                    end
                    check("uart_data", uart_data, exp_bytes[byte_idx]);
                    last_byte = exp_bytes[byte_idx];
                    byte_idx  = (byte_idx + 1) % BPR;
                    start_log.push_back(cyc);
                end else begin
                    check("uart_data_hold", uart_data, last_byte);
                end
                prev_start = uart_start;
                check("fifo_count", fifo_count, m_count);
                check("overflow", overflow, m_ovf);
                check("res_ready", res_ready, ena && (m_count < DEPTH));
            end
        end
    end

    task automatic push(input logic [15:0] d);
        res_valid = 1'b1;
        res_data  = d;
        e0        = cyc + 1;
        @(posedge clock);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clock);
            #1;
            ok = (idle === 1'b1) && (m_q.size() == 0) && (byte_idx == 0) && !uart_busy;
        end
        check({tag, "_drain"}, ok, 1);
    endtask

    task automatic wait_pulses(input string tag, input int n, input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clock);
            #1;
            ok = (start_log.size() >= n);
        end
        check({tag, "_pulse_wait"}, ok, 1);
    endtask

    task automatic check_gaps(input string tag, input int base, input int n, input int gap);
        for (int i = 1; i < n; i++) begin
            if (start_log.size() > base + i)
                check(tag, start_log[base + i] - start_log[base + i - 1], gap);
        end
    endtask

    task automatic apply_reset();
        res_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int  base;
        bit  found;

        ena = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_uart_start", uart_start, 0);
        check("rst_uart_data", uart_data, 8'h00);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;
        @(negedge clock);
        #1;

        // single result, 10-cycle UART occupancy
        busy_len = 10;
        base = start_log.size();
        push(16'h12AB);
        wait_idle("single", 200);
        check("single_pulses", start_log.size() - base, BPR);
        if (start_log.size() > base)
            check("single_latency", start_log[base], e0 + 1);
        check_gaps("single_gap", base, BPR, busy_len + 2);
        check("single_idle", idle, 1);

        // fill with the UART held busy, then release
        force_busy = 1'b1;
        base = start_log.size();
        for (int i = 0; i < 5; i++)
            push({8'(8'h10 + i), 8'(8'hC0 + i)});
        check("fill_count", fifo_count, 4);
        check("fill_ready", res_ready, 0);
        check("fill_overflow", overflow, 1);
        check("fill_no_start", start_log.size() - base, 0);
        force_busy = 1'b0;
        wait_idle("fill", 400);
        check("fill_pulses", start_log.size() - base, 4 * BPR);
        check("overflow_sticky", overflow, 1);
        apply_reset();
        #1;
        check("overflow_cleared", overflow, 0);

        // back-to-back results: every pulse spaced by the busy handshake only
        busy_len = 3;
        base = start_log.size();
        push(16'h0001);
        push(16'h0203);
        wait_idle("b2b", 200);
        check("b2b_pulses", start_log.size() - base, 2 * BPR);
        check_gaps("b2b_gap", base, 2 * BPR, busy_len + 2);

        // ena drop after the high byte
        busy_len = 4;
        base = start_log.size();
        push(16'hBEEF);
        push(16'h1111);
        wait_pulses("ena", base + BPR - 1, 100);
        ena = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        check("ena_finish_result", start_log.size() - base, BPR);
        check("ena_queued", fifo_count, 1);
        check("ena_not_idle", idle, 0);
        ena = 1'b1;
        wait_idle("ena", 200);
        check("ena_resume_pulses", start_log.size() - base, 2 * BPR);

        // async reset while waiting on the high byte
        busy_len = 10;
        base = start_log.size();
        push(16'hC0DE);
        push(16'h7777);
        wait_pulses("rst_wait_hi", base + BPR - 1, 100);
        repeat (2) @(negedge clock);
        #1;
        check("pre_reset_count", fifo_count, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_start", uart_start, 0);
        check("async_rst_count", fifo_count, 0);
        check("async_rst_idle", idle, 1);
        check("async_rst_data", uart_data, 8'h00);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // async reset during a start pulse
        busy_len = 3;
        push(16'h4242);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            #1;
            found = uart_start;
        end
        check("pulse_seen", found, 1);
        reset = 1'b1;
        #1;
        check("async_rst_pulse_drop", uart_start, 0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // UART already busy while idle: no pulse until it frees up
        force_busy = 1'b1;
        base = start_log.size();
        push(16'h9876);
        repeat (20) @(negedge clock);
        #1;
        check("busy_idle_no_start", start_log.size() - base, 0);
        check("busy_idle_count", fifo_count, 1);
        force_busy = 1'b0;
        wait_idle("busy_idle", 200);
        check("busy_idle_pulses", start_log.size() - base, BPR);

        // random traffic with random UART occupancy
        rand_len = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            ena       = ($urandom_range(0, 7) != 0);
            res_valid = ($urandom_range(0, 2) == 0);
            res_data  = 16'($urandom);
        end
        @(posedge clock);
        #1;
        res_valid = 1'b0;
        ena       = 1'b1;
        wait_idle("random", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
